midi_msg_parser: RTL and testbench
==================================

MIDI_MSG_PARSER -- requirements
Module: midi_msg_parser

Interface
REQ-001 SHALL have parameter OMNI, default 1: 1 = accept all channels, 0 = accept only CHANNEL.
REQ-002 SHALL have parameter CHANNEL, default 0: 4-bit channel number used when OMNI=0.
REQ-003 SHALL have port clck, input, 1, single system clock; all flops on posedge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port byte_in, input, 8, received MIDI byte from the upstream receiver.
REQ-006 SHALL have port byte_valid, input, 1, single-cycle strobe; byte_in is valid in that cycle; at most one byte per cycle.
REQ-007 SHALL have port evt_valid, output, 1, single-cycle pulse marking a new note event.
REQ-008 SHALL have port evt_note_on, output, 1, 1 = note-on, 0 = note-off.
REQ-009 SHALL have port evt_channel, output, 4, channel of the event.
REQ-010 SHALL have port evt_note, output, 7, note number.
REQ-011 SHALL have port evt_velocity, output, 7, velocity.
REQ-012 SHALL have port note_count, output, 8, number of currently sounding notes, range 0..128.
REQ-013 SHALL have port led_out, output, 8, {1'b0, evt_note} while note_count>0, else 8'h00.
REQ-014 SHALL have port err_pulse, output, 1, single-cycle pulse on a discarded orphan data byte.

Function
REQ-015 SHALL implement states IDLE (no running status), WAIT_D1, WAIT_D2, SKIP.
REQ-016 SHALL classify byte_in[7]=1 as status and byte_in[7]=0 as data.
REQ-017 SHALL, on status 0x80-0xEF in any state, latch running status and go to WAIT_D1, abandoning any partial message.
REQ-018 SHALL set data length to 2 for 0x8n/0x9n/0xAn/0xBn/0xEn and to 1 for 0xCn/0xDn.
REQ-019 SHALL, on status 0xF0-0xF7, clear running status and go to SKIP; in SKIP, data bytes are dropped silently.
REQ-020 SHALL ignore real-time bytes 0xF8-0xFF in every state, with no change to state, running status, or data latch.
REQ-021 SHALL, on a data byte in IDLE, drop the byte and assert err_pulse in the next cycle.
REQ-022 SHALL, in WAIT_D1, latch the data byte, then go to WAIT_D2 for length 2 or complete the message for length 1.
REQ-023 SHALL, on a data byte in WAIT_D2, complete the message and return to WAIT_D1 with running status retained.
REQ-024 SHALL emit an event only for completed 0x8n/0x9n messages whose channel passes the filter; all other messages are consumed with no output.
REQ-025 SHALL treat 0x9n with velocity 0 as note-off (evt_note_on=0, evt_velocity=0).
REQ-026 SHALL assert evt_valid exactly one cycle after the byte_valid cycle that completes the message.
REQ-027 SHALL register evt_* fields together with evt_valid and hold them until the next event.
REQ-028 SHALL keep a 128-entry active-note bitmap: note-on sets the bit, note-off clears it.
REQ-029 SHALL increment note_count only on a 0->1 bit change and decrement only on 1->0; repeat note-on or orphan note-off leaves the count unchanged.
REQ-030 SHALL update note_count and led_out in the same cycle as evt_valid.
REQ-031 SHALL accept a byte arriving in the same cycle as evt_valid normally, with no stall.

Reset
REQ-032 SHALL, on rst_n low, asynchronously set state=IDLE, running status cleared, bitmap cleared, note_count=0, evt_*=0, evt_valid=0, err_pulse=0, led_out=8'h00.
REQ-033 SHALL discard any partial message in progress on reset; the first post-reset data byte is an orphan.

Structure
REQ-034 SHALL place status-range constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, SYS=8'hF0, RT=8'hF8) and the state enum in shared package midi_pkg.
REQ-035 SHALL implement the bitmap and counter in sub-module midi_note_table (inputs: set/clear strobe, note; outputs: note_count).

Verification
REQ-036 SHALL cover: 90 3C 64 -> evt_valid, on=1, ch=0, note=0x3C, vel=0x64, note_count=1, led_out=0x3C.
REQ-037 SHALL cover running status: 90 3C 64 40 00 -> second event on=0, note=0x40, vel=0; note_count stays 1.
REQ-038 SHALL cover real-time interleave: 90 F8 3C FE 64 -> single note-on event identical to the REQ-036 scenario.
REQ-039 SHALL cover orphan/SysEx: reset, 3C -> err_pulse=1; F0 01 02 F7 3C -> no event and no err_pulse.
REQ-040 SHALL cover the channel filter with OMNI=0, CHANNEL=2: 91 3C 64 -> no event; 92 3C 64 -> event with ch=2.
REQ-041 SHALL cover reset mid-message: 90 3C, rst_n pulse, 64 -> err_pulse=1, no event, note_count=0.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI parser types and constants.
// Status ranges, parser states and the event bundle.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [7:0] SYS      = 8'hF0;
  localparam logic [7:0] RT       = 8'hF8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2,
    SKIP
  } state_t;

  typedef struct packed {
    logic       on;
    logic [3:0] ch;
    logic [6:0] note;
    logic [6:0] vel;
  } evt_t;

  // Program change and channel pressure carry one data byte.
  function automatic logic [1:0] data_len(
    input logic [3:0] hi
  );
    if (hi == 4'hC || hi == 4'hD) begin
      return 2'd1;
    end
    return 2'd2;
  endfunction

endpackage

// File: rtl/midi_note_table.sv
// Active-note bitmap and sounding-note counter.
// Ports: clck, rst_n, set, clr, note -> note_count.
module midi_note_table
  import midi_pkg::*;
(
  input  logic       clck,
  input  logic       rst_n,
  input  logic       set,
  input  logic       clr,
  input  logic [6:0] note,
  output logic [7:0] note_count
);

  logic [127:0] map_q;
  logic [7:0]   cnt_q;

  // Count moves only on real bit transitions.
  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      map_q <= '0;
      cnt_q <= '0;
    end else if (set && !map_q[note]) begin
      map_q[note] <= 1'b1;
      cnt_q       <= cnt_q + 8'd1;
    end else if (clr && map_q[note]) begin
      map_q[note] <= 1'b0;
      cnt_q       <= cnt_q - 8'd1;
    end
  end

  assign note_count = cnt_q;

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser emitting note on/off events.
// Ports: clck, rst_n, byte_in/byte_valid -> evt_*, note_count, led_out, err_pulse.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int         OMNI    = 1,
  parameter logic [3:0] CHANNEL = 4'h0
) (
  input  logic       clck,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       evt_valid,
  output logic       evt_note_on,
  output logic [3:0] evt_channel,
  output logic [6:0] evt_note,
  output logic [6:0] evt_velocity,
  output logic [7:0] note_count,
  output logic [7:0] led_out,
  output logic       err_pulse
);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] status_q;
  logic [7:0] status_d;
  logic [6:0] d1_q;
  logic [6:0] d1_d;
  logic       done;
  logic       orphan;

  logic       chn_b;
  logic       sys_b;
  logic       dat_b;

  logic [3:0] hi;
  logic       is_note;
  logic       ch_ok;
  logic       emit;
  evt_t       evt_d;
  evt_t       evt_q;
  logic       evt_valid_q;
  logic       err_q;

  // Real-time bytes match none of these and fall through.
  assign chn_b = byte_valid & byte_in[7] & (byte_in < SYS);
  assign sys_b = byte_valid & (byte_in >= SYS) & (byte_in < RT);
  assign dat_b = byte_valid & ~byte_in[7];

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    done     = 1'b0;
    orphan   = 1'b0;
    unique case (1'b1)
      chn_b: begin
        status_d = byte_in;
        state_d  = WAIT_D1;
      end
      sys_b: begin
        status_d = '0;
        state_d  = SKIP;
      end
      dat_b: begin
        unique case (state_q)
          IDLE: orphan = 1'b1;
          WAIT_D1: begin
            d1_d = byte_in[6:0];
            if (data_len(status_q[7:4]) == 2'd1) begin
              done = 1'b1;
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            done    = 1'b1;
            state_d = WAIT_D1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      status_q <= '0;
      d1_q     <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
    end
  end

  // Note messages are two-byte, so d1_q is valid when done fires.
  assign hi      = status_q[7:4];
  assign is_note = (hi == NOTE_ON) || (hi == NOTE_OFF);
  assign ch_ok   = (OMNI != 0) || (status_q[3:0] == CHANNEL);
  assign emit    = done & is_note & ch_ok;

  always_comb begin
    evt_d      = '0;
    evt_d.on   = (hi == NOTE_ON) && (byte_in[6:0] != 7'd0);
    evt_d.ch   = status_q[3:0];
    evt_d.note = d1_q;
    evt_d.vel  = byte_in[6:0];
  end

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      evt_q       <= '0;
      evt_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      evt_valid_q <= emit;
      err_q       <= orphan;
      if (emit) begin
        evt_q <= evt_d;
      end
    end
  end

  midi_note_table u_table (
    .clck       (clck),
    .rst_n      (rst_n),
    .set        (emit & evt_d.on),
    .clr        (emit & ~evt_d.on),
    .note       (evt_d.note),
    .note_count (note_count)
  );

  assign evt_valid    = evt_valid_q;
  assign evt_note_on  = evt_q.on;
  assign evt_channel  = evt_q.ch;
  assign evt_note     = evt_q.note;
  assign evt_velocity = evt_q.vel;
  assign err_pulse    = err_q;
  assign led_out      = (note_count != 8'd0)
                      ? {1'b0, evt_q.note} : 8'h00;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Scoreboard bench for midi_msg_parser.
// Two instances: omni (dut1) and channel-2 filtered (dut2).
module tb_midi_msg_parser;

  typedef struct packed {
    logic       on;
    logic [3:0] ch;
    logic [6:0] note;
    logic [6:0] vel;
    logic [7:0] cnt;
    logic [7:0] led;
  } exp_t;

  logic       clck;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [7:0] byte_in2;
  logic       byte_valid2;

  logic       evt_valid, evt_note_on, err_pulse;
  logic [3:0] evt_channel;
  logic [6:0] evt_note, evt_velocity;
  logic [7:0] note_count, led_out;

  logic       evt_valid2, evt_note_on2, err_pulse2;
  logic [3:0] evt_channel2;
  logic [6:0] evt_note2, evt_velocity2;
  logic [7:0] note_count2, led_out2;

  exp_t q1[$];
  exp_t q2[$];
  exp_t act1, exp1, act2, exp2;
  int   checks = 0;
  int   errors = 0;
  int   errs1  = 0;
  int   errs2  = 0;
  bit   model_map[128];
  int   model_cnt;

  midi_msg_parser dut1 (
    .clck(clck), .rst_n(rst_n),
    .byte_in(byte_in), .byte_valid(byte_valid),
    .evt_valid(evt_valid), .evt_note_on(evt_note_on),
    .evt_channel(evt_channel), .evt_note(evt_note),
    .evt_velocity(evt_velocity), .note_count(note_count),
    .led_out(led_out), .err_pulse(err_pulse)
  );

  midi_msg_parser #(.OMNI(0), .CHANNEL(4'd2)) dut2 (
    .clck(clck), .rst_n(rst_n),
    .byte_in(byte_in2), .byte_valid(byte_valid2),
    .evt_valid(evt_valid2), .evt_note_on(evt_note_on2),
    .evt_channel(evt_channel2), .evt_note(evt_note2),
    .evt_velocity(evt_velocity2), .note_count(note_count2),
    .led_out(led_out2), .err_pulse(err_pulse2)
  );

  initial clck = 1'b0;
  always #5 clck = ~clck;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  always @(negedge clck) begin
    if (err_pulse) errs1++;
    if (evt_valid) begin
      act1 = {evt_note_on, evt_channel, evt_note,
              evt_velocity, note_count, led_out};
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL evt1 unexpected act=%h", act1);
      end else begin
        exp1 = q1.pop_front();
        if (act1 !== exp1) begin
          errors++;
          $display("FAIL evt1 act=%h exp=%h", act1, exp1);
        end
      end
    end
  end

  always @(negedge clck) begin
    if (err_pulse2) errs2++;
    if (evt_valid2) begin
      act2 = {evt_note_on2, evt_channel2, evt_note2,
              evt_velocity2, note_count2, led_out2};
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL evt2 unexpected act=%h", act2);
      end else begin
        exp2 = q2.pop_front();
        if (act2 !== exp2) begin
          errors++;
          $display("FAIL evt2 act=%h exp=%h", act2, exp2);
        end
      end
    end
  end

  function automatic void expect1(
    input bit on, input logic [3:0] ch,
    input logic [6:0] n, input logic [6:0] v
  );
    exp_t e;
    if (on) begin
      if (!model_map[n]) begin
        model_map[n] = 1'b1;
        model_cnt++;
      end
    end else if (model_map[n]) begin
      model_map[n] = 1'b0;
      model_cnt--;
    end
    e.on   = on;
    e.ch   = ch;
    e.note = n;
    e.vel  = v;
    e.cnt  = model_cnt[7:0];
    e.led  = (model_cnt > 0) ? {1'b0, n} : 8'h00;
    q1.push_back(e);
  endfunction

  task automatic send(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clck);
    byte_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    byte_in2    = b;
    byte_valid2 = 1'b1;
    @(negedge clck);
    byte_valid2 = 1'b0;
  endtask

  task automatic do_reset();
    byte_valid  = 1'b0;
    byte_valid2 = 1'b0;
    rst_n       = 1'b0;
    repeat (2) @(negedge clck);
    rst_n = 1'b1;
    foreach (model_map[i]) model_map[i] = 1'b0;
    model_cnt = 0;
    @(negedge clck);
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clck);
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL %s missing events q1=%0d q2=%0d exp=0",
               name, q1.size(), q2.size());
    end
  endtask

  task automatic test_reset();
    byte_in     = 8'h00;
    byte_in2    = 8'h00;
    byte_valid  = 1'b0;
    byte_valid2 = 1'b0;
    rst_n       = 1'b0;
    #3;
    checks++;
    if ({evt_valid, evt_note_on, evt_channel, evt_note,
         evt_velocity, note_count, led_out, err_pulse} !== '0) begin
      errors++;
      $display("FAIL reset1 cnt=%h led=%h v=%b exp=0",
               note_count, led_out, evt_valid);
    end
    checks++;
    if ({evt_valid2, evt_note_on2, evt_channel2, evt_note2,
         evt_velocity2, note_count2, led_out2, err_pulse2} !== '0) begin
      errors++;
      $display("FAIL reset2 cnt=%h led=%h v=%b exp=0",
               note_count2, led_out2, evt_valid2);
    end
    @(negedge clck);
    do_reset();
  endtask

  task automatic test_note_on();
    do_reset();
    send(8'h90);
    send(8'h3C);
    expect1(1'b1, 4'h0, 7'h3C, 7'h64);
    send(8'h64);
    checks++;
    if (evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL evt_latency act=%b exp=1", evt_valid);
    end
    @(negedge clck);
    checks++;
    if (evt_valid !== 1'b0 || evt_note !== 7'h3C) begin
      errors++;
      $display("FAIL evt_hold v=%b note=%h exp v=0 note=3c",
               evt_valid, evt_note);
    end
    drain("note_on");
    checks++;
    if (note_count !== 8'd1 || led_out !== 8'h3C) begin
      errors++;
      $display("FAIL note_on_state cnt=%0d led=%h exp 1 3c",
               note_count, led_out);
    end
  endtask

  task automatic test_running_status();
    do_reset();
    send(8'h90);
    send(8'h3C);
    expect1(1'b1, 4'h0, 7'h3C, 7'h64);
    send(8'h64);
    send(8'h40);
    expect1(1'b0, 4'h0, 7'h40, 7'h00);
    send(8'h00);
    drain("running");
    checks++;
    if (note_count !== 8'd1) begin
      errors++;
      $display("FAIL running_cnt act=%0d exp=1", note_count);
    end
  endtask

  task automatic test_realtime();
    do_reset();
    send(8'h90);
    send(8'hF8);
    send(8'h3C);
    send(8'hFE);
    expect1(1'b1, 4'h0, 7'h3C, 7'h64);
    send(8'h64);
    drain("realtime");
  endtask

  task automatic test_orphan();
    int e0;
    do_reset();
    e0 = errs1;
    send(8'h3C);
    checks++;
    if (err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL orphan_pulse act=%b exp=1", err_pulse);
    end
    repeat (2) @(negedge clck);
    checks++;
    if (errs1 - e0 != 1) begin
      errors++;
      $display("FAIL orphan_count act=%0d exp=1", errs1 - e0);
    end
    e0 = errs1;
    send(8'hF0);
    send(8'h01);
    send(8'h02);
    send(8'hF7);
    send(8'h3C);
    drain("sysex");
    checks++;
    if (errs1 - e0 != 0) begin
      errors++;
      $display("FAIL sysex_err act=%0d exp=0", errs1 - e0);
    end
  endtask

  task automatic test_filter();
    exp_t e;
    do_reset();
    send2(8'h91);
    send2(8'h3C);
    send2(8'h64);
    send2(8'h92);
    send2(8'h3C);
    e = {1'b1, 4'h2, 7'h3C, 7'h64, 8'd1, 8'h3C};
    q2.push_back(e);
    send2(8'h64);
    drain("filter");
    checks++;
    if (note_count2 !== 8'd1 || errs2 != 0) begin
      errors++;
      $display("FAIL filter_state cnt=%0d err=%0d exp 1 0",
               note_count2, errs2);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    do_reset();
    send(8'h90);
    send(8'h3C);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    foreach (model_map[i]) model_map[i] = 1'b0;
    model_cnt = 0;
    @(negedge clck);
    e0 = errs1;
    send(8'h64);
    drain("reset_mid");
    checks++;
    if (errs1 - e0 != 1 || note_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid err=%0d cnt=%0d exp 1 0",
               errs1 - e0, note_count);
    end
  endtask

  task automatic test_back_to_back();
    int         e0, k, rs;
    logic [3:0] ch, rch;
    logic [6:0] n, v;
    do_reset();
    e0  = errs1;
    rs  = 0;
    rch = 4'h0;
    for (int i = 0; i < 60; i++) begin
      k  = $urandom_range(0, 3);
      ch = 4'($urandom_range(0, 15));
      n  = 7'(8'h30 + $urandom_range(0, 7));
      v  = ($urandom_range(0, 3) == 0)
         ? 7'd0 : 7'($urandom_range(1, 127));
      if (k == 1 && rs == 0) k = 0;
      if ($urandom_range(0, 4) == 0) send(8'hF8);
      case (k)
        0: begin
          send({4'h9, ch});
          rs = 9; rch = ch;
          send({1'b0, n});
          expect1(v != 0, ch, n, v);
          send({1'b0, v});
        end
        1: begin
          send({1'b0, n});
          expect1(rs == 9 && v != 0, rch, n, v);
          send({1'b0, v});
        end
        2: begin
          send({4'h8, ch});
          rs = 8; rch = ch;
          send({1'b0, n});
          expect1(1'b0, ch, n, v);
          send({1'b0, v});
        end
        default: begin
          send({4'hC, ch});
          send({1'b0, n});
          rs = 0;
        end
      endcase
    end
    drain("back_to_back");
    checks++;
    if (note_count !== model_cnt[7:0] || errs1 != e0) begin
      errors++;
      $display("FAIL b2b_state cnt=%0d exp=%0d err=%0d",
               note_count, model_cnt, errs1 - e0);
    end
  endtask

  task automatic test_full();
    do_reset();
    send(8'h90);
    for (int i = 0; i < 128; i++) begin
      send(8'(i));
      expect1(1'b1, 4'h0, 7'(i), 7'd1);
      send(8'h01);
    end
    send(8'h7F);
    expect1(1'b1, 4'h0, 7'h7F, 7'h05);
    send(8'h05);
    drain("full");
    checks++;
    if (note_count !== 8'd128) begin
      errors++;
      $display("FAIL full_cnt act=%0d exp=128", note_count);
    end
    send(8'h80);
    send(8'h00);
    expect1(1'b0, 4'h0, 7'h00, 7'h00);
    send(8'h00);
    drain("full_off");
    checks++;
    if (note_count !== 8'd127) begin
      errors++;
      $display("FAIL full_off_cnt act=%0d exp=127", note_count);
    end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_orphan();
    test_filter();
    test_reset_mid();
    test_back_to_back();
    test_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
